// File: rtl/adc_spi_multi_master.sv
`timescale 1ns/1ps
// SPI master for NUM_ADC dual-channel SAR ADCs sharing one SCLK and chip-select.
// Each frame shifts one command per ADC and captures two results per ADC in lockstep.
module adc_spi_multi_master #(
    parameter int NUM_ADC   = 2,
    parameter int CMD_W     = 16,
    parameter int DATA_LEAD = 2,
    parameter int DATA_W    = 14,
    parameter int CLK_DIV   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic [NUM_ADC*CMD_W-1:0]  cmd,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_ADC*DATA_W-1:0] data_a,
    output logic [NUM_ADC*DATA_W-1:0] data_b,
    output logic                      sclk,
    output logic                      ss_n,
    output logic [NUM_ADC-1:0]        mosi,
    output logic [NUM_ADC-1:0]        mosi_oe,
    input  logic [NUM_ADC-1:0]        miso_a,
    input  logic [NUM_ADC-1:0]        miso_b
);

    localparam int FRAME  = CMD_W + DATA_LEAD + DATA_W;
    localparam int EDGES  = 2 * FRAME;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam int TX_W   = $clog2(CMD_W + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] bit_idx;
    logic [TX_W-1:0]   tx_cnt;
    logic              cpol_q, cpha_q;
    logic [CMD_W-1:0]  cmd_sr [NUM_ADC];
    logic [DATA_W-1:0] rx_a   [NUM_ADC];
    logic [DATA_W-1:0] rx_b   [NUM_ADC];

    logic div_end, accept, sclk_edge, last_edge, leading, tx_step, rx_step, frame_end;

    // Even edge numbers are leading edges; cpha selects which half moves mosi.
    assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign accept    = (state == IDLE) && start && !done;
    assign sclk_edge = (state == SHIFT) && div_end;
    assign last_edge = sclk_edge && (edge_cnt == EDGE_W'(EDGES - 1));
    assign leading   = ~edge_cnt[0];
    assign bit_idx   = {1'b0, edge_cnt[EDGE_W-1:1]};
    assign tx_step   = sclk_edge && (leading == cpha_q);
    assign rx_step   = sclk_edge && (leading != cpha_q) &&
                       (bit_idx >= EDGE_W'(CMD_W + DATA_LEAD));
    assign frame_end = (state == HOLD) && div_end;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SETUP;
            SETUP:   if (div_end)   state_next = SHIFT;
            SHIFT:   if (last_edge) state_next = HOLD;
            HOLD:    if (div_end)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_cnt   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk     <= 1'b0;
            ss_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            mosi     <= '0;
            mosi_oe  <= '0;
            data_a   <= '0;
            data_b   <= '0;
            for (int i = 0; i < NUM_ADC; i++) begin
                cmd_sr[i] <= '0;
                rx_a[i]   <= '0;
                rx_b[i]   <= '0;
            end
        end else begin
            done <= 1'b0;

            if (state == IDLE || div_end) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state == IDLE) begin
                edge_cnt <= '0;
            end else if (sclk_edge) begin
                edge_cnt <= edge_cnt + 1'b1;
            end

            if (sclk_edge) begin
                sclk <= ~sclk;
            end else if (state == IDLE) begin
                sclk <= accept ? cpol : cpol_q;
            end

            // With cpha=0 the first command bit must already be on mosi before the first edge.
            if (accept) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                ss_n    <= 1'b0;
                busy    <= 1'b1;
                tx_cnt  <= cpha ? TX_W'(0) : TX_W'(1);
                mosi_oe <= cpha ? '0 : '1;
                for (int i = 0; i < NUM_ADC; i++) begin
                    mosi[i]   <= cpha ? 1'b0 : cmd[i*CMD_W + CMD_W - 1];
                    cmd_sr[i] <= cpha ? cmd[i*CMD_W +: CMD_W] : (cmd[i*CMD_W +: CMD_W] << 1);
                end
            end else if (tx_step) begin
                if (tx_cnt < TX_W'(CMD_W)) begin
                    tx_cnt  <= tx_cnt + 1'b1;
                    mosi_oe <= '1;
                    for (int i = 0; i < NUM_ADC; i++) begin
                        mosi[i]   <= cmd_sr[i][CMD_W-1];
                        cmd_sr[i] <= cmd_sr[i] << 1;
                    end
                end else begin
                    mosi    <= '0;
                    mosi_oe <= '0;
                end
            end

            if (rx_step) begin
                for (int i = 0; i < NUM_ADC; i++) begin
                    rx_a[i] <= {rx_a[i][DATA_W-2:0], miso_a[i]};
                    rx_b[i] <= {rx_b[i][DATA_W-2:0], miso_b[i]};
                end
            end

            // Results become visible only here, so partial shifts never reach the outputs.
            if (frame_end) begin
                ss_n <= 1'b1;
                busy <= 1'b0;
                done <= 1'b1;
                for (int i = 0; i < NUM_ADC; i++) begin
                    data_a[i*DATA_W +: DATA_W] <= rx_a[i];
                    data_b[i*DATA_W +: DATA_W] <= rx_b[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_multi_master.sv
`timescale 1ns/1ps
// Directed bench for adc_spi_multi_master: default two-ADC build plus a small one-ADC build,
// each driven by a behavioural AD7264-style slave.
module tb_adc_spi_multi_master;

    logic        clk, resetn;
    logic        start, cpol, cpha;
    logic [31:0] cmd;
    logic        busy, done, sclk, ss_n;
    logic [27:0] data_a, data_b;
    logic [1:0]  mosi, mosi_oe, miso_a, miso_b;

    logic        start2, cpol2, cpha2;
    logic [7:0]  cmd2;
    logic        busy2, done2, sclk2, ss_n2;
    logic [11:0] data_a2, data_b2;
    logic [0:0]  mosi2, mosi_oe2, miso_a2, miso_b2;

    int checks = 0;
    int failures = 0;

    adc_spi_multi_master dut (
        .clk(clk), .resetn(resetn), .start(start), .cpol(cpol), .cpha(cpha), .cmd(cmd),
        .busy(busy), .done(done), .data_a(data_a), .data_b(data_b), .sclk(sclk),
        .ss_n(ss_n), .mosi(mosi), .mosi_oe(mosi_oe), .miso_a(miso_a), .miso_b(miso_b)
    );

    adc_spi_multi_master #(
        .NUM_ADC(1), .CMD_W(8), .DATA_LEAD(0), .DATA_W(12), .CLK_DIV(2)
    ) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .cpol(cpol2), .cpha(cpha2), .cmd(cmd2),
        .busy(busy2), .done(done2), .data_a(data_a2), .data_b(data_b2), .sclk(sclk2),
        .ss_n(ss_n2), .mosi(mosi2), .mosi_oe(mosi_oe2), .miso_a(miso_a2), .miso_b(miso_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave for the default build: 16 command bits, 2 lead bits, 14 data bits.
    logic [13:0] sa [2];
    logic [13:0] sb [2];
    logic [15:0] cap1 [2];
    int          cap1_oe = 0;
    logic        s1_cpha = 1'b0;
    int          s1_edges = 0;
    logic        s1_prev_sclk = 1'b0;
    logic        s1_prev_ss = 1'b1;

    always @(negedge clk) begin : slave1
        int e, k, d;
        if (!ss_n && s1_prev_ss) begin
            s1_edges = 0;
            cap1[0] = '0;
            cap1[1] = '0;
            cap1_oe = 0;
        end else if (!ss_n && (sclk !== s1_prev_sclk)) begin
            s1_edges++;
            e = s1_edges;
            if (((e % 2) == 1) == (s1_cpha == 1'b0)) begin
                k = s1_cpha ? (e / 2 - 1) : ((e - 1) / 2);
                if (mosi_oe[0]) cap1_oe++;
                if (k < 16) begin
                    for (int i = 0; i < 2; i++) cap1[i] = {cap1[i][14:0], mosi[i]};
                end
            end
        end
        if (ss_n) s1_edges = 0;
        s1_prev_sclk = sclk;
        s1_prev_ss = ss_n;
        k = s1_cpha ? ((s1_edges + 1) / 2 - 1) : (s1_edges / 2);
        d = k - 18;
        for (int i = 0; i < 2; i++) begin
            miso_a[i] = (d >= 0 && d < 14) ? sa[i][13-d] : 1'b1;
            miso_b[i] = (d >= 0 && d < 14) ? sb[i][13-d] : 1'b1;
        end
    end

    // Slave for the small build: 8 command bits, no lead, 12 data bits.
    logic [11:0] sa2, sb2;
    logic [7:0]  cap2;
    int          cap2_oe = 0;
    logic        s2_cpha = 1'b0;
    int          s2_edges = 0;
    logic        s2_prev_sclk = 1'b0;
    logic        s2_prev_ss = 1'b1;

    always @(negedge clk) begin : slave2
        int e, k, d;
        if (!ss_n2 && s2_prev_ss) begin
            s2_edges = 0;
            cap2 = '0;
            cap2_oe = 0;
        end else if (!ss_n2 && (sclk2 !== s2_prev_sclk)) begin
            s2_edges++;
            e = s2_edges;
            if (((e % 2) == 1) == (s2_cpha == 1'b0)) begin
                k = s2_cpha ? (e / 2 - 1) : ((e - 1) / 2);
                if (mosi_oe2[0]) cap2_oe++;
                if (k < 8) cap2 = {cap2[6:0], mosi2[0]};
            end
        end
        if (ss_n2) s2_edges = 0;
        s2_prev_sclk = sclk2;
        s2_prev_ss = ss_n2;
        k = s2_cpha ? ((s2_edges + 1) / 2 - 1) : (s2_edges / 2);
        d = k - 8;
        miso_a2[0] = (d >= 0 && d < 12) ? sa2[11-d] : 1'b1;
        miso_b2[0] = (d >= 0 && d < 12) ? sb2[11-d] : 1'b1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int done_at, busy_cnt, extra_cnt;
    logic idle_sclk;

    // One frame on the default build; pulses=1 adds stray starts and mid-frame input changes.
    task automatic apply_stimulus(input logic p_cpol, input logic p_cpha,
                                  input logic [31:0] p_cmd, input bit pulses);
        @(negedge clk);
        cpol = p_cpol; cpha = p_cpha; cmd = p_cmd; s1_cpha = p_cpha; start = 1'b1;
        @(posedge clk);
        done_at = 0; busy_cnt = 0; extra_cnt = 0;
        for (int n = 1; n <= 400 && done_at == 0; n++) begin
            @(negedge clk);
            start = pulses && (n == 10 || n == 100);
            if (pulses && n == 10) begin
                cpol = ~p_cpol; cpha = ~p_cpha; cmd = ~p_cmd;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n;
                start = pulses;
            end
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (!ss_n || done) extra_cnt++;
        end
        idle_sclk = sclk;
    endtask

    task automatic check_frame(input string tag, input logic p_cpol, input logic [31:0] p_cmd);
        check_output({tag, " done_cycle"}, done_at, 265);
        check_output({tag, " busy_cycles"}, busy_cnt, 264);
        check_output({tag, " no_extra_frame"}, extra_cnt, 0);
        check_output({tag, " data_a"}, data_a, {sa[1], sa[0]});
        check_output({tag, " data_b"}, data_b, {sb[1], sb[0]});
        check_output({tag, " mosi_adc0"}, cap1[0], p_cmd[15:0]);
        check_output({tag, " mosi_adc1"}, cap1[1], p_cmd[31:16]);
        check_output({tag, " mosi_oe_cycles"}, cap1_oe, 16);
        check_output({tag, " sclk_idle"}, idle_sclk, p_cpol);
    endtask

    localparam logic [31:0] MAIN_CMD = {16'h3C5A, 16'hA5C3};
    localparam logic [31:0] NEXT_CMD = {16'h0FF0, 16'h8001};

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int n, m;
        resetn = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; cmd = '0;
        start2 = 1'b0; cpol2 = 1'b0; cpha2 = 1'b0; cmd2 = '0;
        sa[0] = 14'h1234; sb[0] = 14'h2ABC; sa[1] = 14'h0001; sb[1] = 14'h3FFF;
        sa2 = 12'hABC; sb2 = 12'h5A3;
        repeat (3) @(negedge clk);

        check_output("reset ss_n", ss_n, 1'b1);
        check_output("reset sclk", sclk, 1'b0);
        check_output("reset busy", busy, 1'b0);
        check_output("reset done", done, 1'b0);
        check_output("reset mosi", mosi, 2'b00);
        check_output("reset mosi_oe", mosi_oe, 2'b00);
        check_output("reset data_a", data_a, 28'h0);
        check_output("reset data_b", data_b, 28'h0);
        check_output("reset small ss_n", ss_n2, 1'b1);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int mode = 0; mode < 4; mode++) begin
            logic [1:0] mv;
            mv = 2'(mode);
            apply_stimulus(mv[1], mv[0], MAIN_CMD, 1'b0);
            check_frame($sformatf("mode%0d%0d", mv[1], mv[0]), mv[1], MAIN_CMD);
        end

        $display("[TB] stray starts and mid-frame input changes");
        apply_stimulus(1'b0, 1'b0, MAIN_CMD, 1'b1);
        check_frame("pulses", 1'b0, MAIN_CMD);

        $display("[TB] reset in mid-frame");
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b1; cmd = MAIN_CMD; s1_cpha = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check_output("abort ss_n", ss_n, 1'b1);
        check_output("abort sclk", sclk, 1'b0);
        check_output("abort busy", busy, 1'b0);
        check_output("abort data_a", data_a, 28'h0);
        check_output("abort data_b", data_b, 28'h0);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        extra_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) extra_cnt++;
        end
        check_output("abort no_done", extra_cnt, 0);
        apply_stimulus(1'b1, 1'b1, MAIN_CMD, 1'b0);
        check_frame("after_abort", 1'b1, MAIN_CMD);

        $display("[TB] back-to-back with start held");
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; cmd = MAIN_CMD; s1_cpha = 1'b0; start = 1'b1;
        @(posedge clk);
        n = 0;
        for (int i = 1; i <= 400 && n == 0; i++) begin
            @(negedge clk);
            if (done) n = i;
        end
        check_output("b2b first done_cycle", n, 265);
        check_output("b2b first data_a", data_a, {14'h0001, 14'h1234});
        sa[0] = 14'h0F0F; sb[0] = 14'h3001; sa[1] = 14'h2AAA; sb[1] = 14'h1555;
        cmd = NEXT_CMD;
        m = 0;
        for (int i = 1; i <= 400 && m == 0; i++) begin
            @(negedge clk);
            if (i == 2) check_output("b2b ss_n low", ss_n, 1'b0);
            if (i == 100) check_output("b2b data_a held", data_a, {14'h0001, 14'h1234});
            if (i == 100) check_output("b2b data_b held", data_b, {14'h3FFF, 14'h2ABC});
            if (done) m = i;
        end
        start = 1'b0;
        check_output("b2b second done_cycle", m, 266);
        check_output("b2b second data_a", data_a, {14'h2AAA, 14'h0F0F});
        check_output("b2b second data_b", data_b, {14'h1555, 14'h3001});
        check_output("b2b second mosi_adc0", cap1[0], 16'h8001);
        check_output("b2b second mosi_adc1", cap1[1], 16'h0FF0);

        $display("[TB] one-ADC build");
        repeat (5) @(negedge clk);
        cpol2 = 1'b0; cpha2 = 1'b1; cmd2 = 8'hC6; s2_cpha = 1'b1; start2 = 1'b1;
        @(posedge clk);
        n = 0; busy_cnt = 0;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (busy2) busy_cnt++;
            if (done2) n = i;
        end
        check_output("small done_cycle", n, 85);
        check_output("small busy_cycles", busy_cnt, 84);
        check_output("small data_a", data_a2, 12'hABC);
        check_output("small data_b", data_b2, 12'h5A3);
        check_output("small mosi", cap2, 8'hC6);
        check_output("small mosi_oe_cycles", cap2_oe, 8);
        @(negedge clk);
        check_output("small done pulse", done2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_spi_multi_master.md
Name: adc_spi_multi_master

Overview:
- Parametrised SPI master for NUM_ADC dual-channel SAR ADCs (AD7264 class) that share one SCLK and one chip-select.
- Generates SCLK from the system clock through a programmable divider and supports all four CPOL/CPHA modes.
- Per frame, it serialises a CMD_W-bit command to each ADC and deserialises two DATA_W-bit results per ADC (channels A and B).
- Sits between the NIOS-side register interface and the sonar ADC pins, with a start/busy/done handshake.

Parameters:
NUM_ADC, 2, number of ADC devices (independent MOSI/MISO_A/MISO_B per device)
CMD_W, 16, command bits shifted out per frame, MSB first
DATA_LEAD, 2, SCLK cycles discarded between the command and data phases
DATA_W, 14, result bits captured per channel, MSB first
CLK_DIV, 4, system clocks per SCLK half-period (>=2)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  request one frame; sampled only in IDLE
cpol  in  1  SCLK idle level; latched at accepted start
cpha  in  1  0 = capture on leading edge, 1 = capture on trailing edge; latched at accepted start
cmd  in  NUM_ADC*CMD_W  command words, ADC i at [i*CMD_W +: CMD_W]; latched at accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when results are valid
data_a  out  NUM_ADC*DATA_W  channel A results, ADC i at [i*DATA_W +: DATA_W]
data_b  out  NUM_ADC*DATA_W  channel B results, same packing as data_a
sclk  out  1  SPI clock
ss_n  out  1  shared chip-select, active low
mosi  out  NUM_ADC  serial command data
mosi_oe  out  NUM_ADC  high only during the command phase; pad tri-state control
miso_a  in  NUM_ADC  channel A serial data
miso_b  in  NUM_ADC  channel B serial data

Behaviour:
- Reset values (async, immediate):
  - FSM in IDLE.
  - ss_n=1, sclk=0, busy=0, done=0.
  - mosi=0, mosi_oe=0.
  - data_a=0, data_b=0.
  - Latched cpol/cpha=0.
- FRAME = CMD_W + DATA_LEAD + DATA_W SCLK cycles (32 with defaults).
- States:
  - IDLE: sclk=latched cpol. When start=1, latch cpol, cpha and cmd, then go to SETUP.
  - SETUP: ss_n=0 and busy=1 for CLK_DIV cycles. When cpha=0, mosi presents cmd MSB from the first SETUP cycle.
  - SHIFT: 2*CLK_DIV*FRAME cycles. A divider counter toggles sclk every CLK_DIV cycles, giving FRAME full SCLK periods and ending at the idle level.
    - cpha=0: sample miso on leading edges, advance mosi on trailing edges.
    - cpha=1: advance mosi on leading edges, sample on trailing edges.
  - HOLD: ss_n=0 for CLK_DIV cycles after the final edge. Then go to IDLE, and in that same cycle: ss_n=1, busy=0, done=1, data_a/data_b updated.
- Bit-index rules (k = SCLK cycle index, 0..FRAME-1):
  - k < CMD_W: mosi_oe=1, mosi=cmd bit CMD_W-1-k.
  - k >= CMD_W: mosi_oe=0, mosi=0.
  - CMD_W <= k < CMD_W+DATA_LEAD: samples discarded.
  - Remaining DATA_W samples are shifted into per-ADC, per-channel internal registers MSB first.
- Latency: done asserts exactly CLK_DIV*(2*FRAME+2)+1 clk cycles after the edge that sampled start (265 with defaults).
- Output hold: data_a/data_b change only in the done cycle and otherwise hold their last value; internal shift registers never leak partial results.
- start while busy: ignored, with no queuing. start high in the done cycle: ignored. start held high: a new frame is accepted on the first IDLE cycle after done.
- cpol/cpha/cmd changes during a frame: no effect until the next accepted start.
- resetn low mid-frame: immediate abort to the reset values; no done pulse; previous results are cleared to 0.
- All ADCs are captured in lockstep; NUM_ADC=1 must elaborate.

Test Plan:
- Defaults, cpol=0, cpha=0, cmd ADC0=16'hA5C3, ADC1=16'h3C5A; slave model returns A0=14'h1234, B0=14'h2ABC, A1=14'h0001, B1=14'h3FFF -> mosi sequences match cmd MSB-first with mosi_oe high for 16 SCLK cycles; done at cycle 265; data_a={14'h0001,14'h1234}, data_b={14'h3FFF,14'h2ABC}.
- Repeat for modes (0,1), (1,0), (1,1) with the same data -> identical results; sclk idles at cpol; sample edges match cpha.
- start pulsed at cycles 10 and 100 of a frame and in the done cycle -> exactly one frame; busy contiguous; one done pulse.
- resetn asserted at cycle 150 of a frame -> ss_n=1, sclk=0, data_a=data_b=0 immediately; no done; a following start completes normally.
- Back-to-back with start held high -> second frame's ss_n falls one cycle after done; previous data held until the second done.
- NUM_ADC=1, CMD_W=8, DATA_LEAD=0, DATA_W=12, CLK_DIV=2 -> FRAME=20; done at 2*(2*20+2)+1=85 cycles; 12-bit results correct.
